// File: rtl/code_loader_pkg.sv
// Shared constants for the code loader: FSM state encodings and default widths.
// The checksum feature is selected by the CODE_LOADER_CHECKSUM_EN macro.
package code_loader_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int WORD_W_DEF = 16;
    localparam int LEN_W      = 9;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        CSUM    = 4'd6,
        DONE    = 4'd7,
        ERR     = 4'd8
    } state_t;

endpackage

// File: rtl/code_loader.sv
// Byte-stream program loader: length header, big-endian words, optional checksum byte.
// Define CODE_LOADER_CHECKSUM_EN to enable the trailing XOR checksum check.
module code_loader
    import code_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              code_w_en,
    output logic [ADDR_W-1:0] code_addr_in,
    output logic [WORD_W-1:0] code_in,
    output logic              run,
    output logic              error,
    output logic [3:0]        dbg_state
);

    // Handshake: a byte moves on a rising edge where in_valid and in_ready are both high.

    state_t              r_state;
    state_t              w_next;
    state_t              w_after_data;
    logic [LEN_W-1:0]    r_len;
    logic [ADDR_W-1:0]   r_idx;
    logic [7:0]          r_hi;
    logic [ADDR_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_code;
    logic                w_accept;
    logic                w_last;
    logic                w_start_ok;
`ifdef CODE_LOADER_CHECKSUM_EN
    logic [7:0]          r_csum;
`endif

    assign w_accept   = in_valid && in_ready;
    assign w_last     = (int'(r_idx) + 1) == int'(r_len);
    assign w_start_ok = start && (r_state == IDLE || r_state == DONE || r_state == ERR);

`ifdef CODE_LOADER_CHECKSUM_EN
    assign w_after_data = CSUM;
`else
    assign w_after_data = DONE;
`endif

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        unique case (r_state)
            IDLE:    if (start) w_next = LEN_HI;
            LEN_HI: begin
                in_ready = 1'b1;
                if (w_accept) w_next = (in_data[7:1] != 7'd0) ? ERR : LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (w_accept) w_next = ({r_len[8], in_data} == 9'd0) ? w_after_data : DATA_HI;
            end
            DATA_HI: begin
                in_ready = 1'b1;
                if (w_accept) w_next = DATA_LO;
            end
            DATA_LO: begin
                in_ready = 1'b1;
                if (w_accept) w_next = WRITE;
            end
            WRITE:   w_next = w_last ? w_after_data : DATA_HI;
            CSUM: begin
`ifdef CODE_LOADER_CHECKSUM_EN
                in_ready = 1'b1;
                if (w_accept) w_next = (in_data == r_csum) ? DONE : ERR;
`else
                w_next = DONE;
`endif
            end
            DONE:    if (start) w_next = LEN_HI;
            ERR:     if (start) w_next = LEN_HI;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len  <= '0;
            r_idx  <= '0;
            r_hi   <= '0;
            r_addr <= '0;
            r_code <= '0;
        end else begin
            if (w_start_ok) begin
                r_len <= '0;
                r_idx <= '0;
            end
            if (w_accept && r_state == LEN_HI)  r_len[8]   <= in_data[0];
            if (w_accept && r_state == LEN_LO)  r_len[7:0] <= in_data;
            if (w_accept && r_state == DATA_HI) r_hi       <= in_data;
            // Write port registers only change on the cycle before WRITE, so they hold otherwise.
            if (w_accept && r_state == DATA_LO) begin
                r_addr <= r_idx;
                r_code <= WORD_W'({r_hi, in_data});
            end
            if (r_state == WRITE) r_idx <= r_idx + 1'b1;
        end
    end

`ifdef CODE_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             r_csum <= '0;
        else if (w_start_ok)                    r_csum <= '0;
        else if (w_accept && r_state != CSUM)   r_csum <= r_csum ^ in_data;
    end
`endif

    assign code_w_en    = (r_state == WRITE);
    assign code_addr_in = r_addr;
    assign code_in      = r_code;
    assign run          = (r_state == DONE);
    assign error        = (r_state == ERR);
    assign dbg_state    = r_state;

endmodule
